// File: rtl/uart_arb_pkg.sv
// Shared definitions for the two-requester UART transmit arbiter.
//   arb_state_e : arbiter FSM states (IDLE -> STROBE -> GAP -> WAIT -> IDLE)
//   NUM_REQ     : number of requesters sharing the serializer
//   LINE_FEED   : byte that ends a line and releases the line lock
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_GAP    = 2'd2,
    ST_WAIT   = 2'd3
  } arb_state_e;

  localparam int NUM_REQ = 2;
  localparam logic [7:0] LINE_FEED = 8'h0A;

endpackage

// File: rtl/uart_byte_fifo.sv
// Per-requester byte FIFO feeding the UART transmit arbiter.
// Ports:
//   i_clk, i_reset : clock and synchronous active-high reset
//   push_i, data_i : write a byte (ignored while full_o is high)
//   pop_i          : discard the head byte (ignored while empty)
//   data_o         : head byte, valid whenever empty_o is low
//   full_o         : registered, high when count reaches DEPTH
//   empty_o        : high when no byte is buffered
//   count_o        : number of buffered bytes, 0..DEPTH
// DEPTH must be a power of two, at least 2, so the pointers wrap for free.
module uart_byte_fifo
  import uart_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   push_i,
  input  logic [7:0]             data_i,
  input  logic                   pop_i,
  output logic [7:0]             data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             full_q;
  logic             push_ok;
  logic             pop_ok;

  // A push on a full FIFO is dropped outright, so push and pop never
  // collide on a full buffer.
  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
    end
  end

  // Storage carries no reset; the pointers define which entries are live.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter in front of a byte-wide UART serializer.
// Each requester owns a small FIFO; the arbiter pops one byte at a time,
// presents it on o_tx_data and pulses o_tx_stb for one cycle.  With line
// locking enabled, the requester that sends a non-line-feed byte keeps the
// line until it sends a line feed or goes quiet for LOCK_TIMEOUT cycles.
// Ports:
//   i_clk, i_reset               : clock, synchronous active-high reset
//   i_reqN_data/i_reqN_stb       : requester N byte and write strobe
//   o_reqN_busy                  : requester N FIFO full (push is dropped)
//   o_tx_data/o_tx_stb           : byte and one-cycle strobe to serializer
//   i_tx_busy                    : serializer busy
//   o_owner                      : requester of the most recently sent byte
//   o_locked                     : line lock held by o_owner
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int LINE_LOCK    = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_req0_data,
  input  logic       i_req0_stb,
  output logic       o_req0_busy,
  input  logic [7:0] i_req1_data,
  input  logic       i_req1_stb,
  output logic       o_req1_busy,
  output logic [7:0] o_tx_data,
  output logic       o_tx_stb,
  input  logic       i_tx_busy,
  output logic       o_owner,
  output logic       o_locked
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int IDLE_W = $clog2(LOCK_TIMEOUT + 1);

  logic [7:0]         req_data   [NUM_REQ];
  logic [NUM_REQ-1:0] req_stb;
  logic [7:0]         fifo_head  [NUM_REQ];
  logic [CNT_W-1:0]   fifo_count [NUM_REQ];
  logic [NUM_REQ-1:0] fifo_full;
  logic [NUM_REQ-1:0] fifo_empty;
  logic [NUM_REQ-1:0] fifo_pop;

  arb_state_e        state_q, state_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              owner_q, owner_d;
  logic              locked_q, locked_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              grant;
  logic              grant_valid;

  assign req_data[0] = i_req0_data;
  assign req_data[1] = i_req1_data;
  assign req_stb     = {i_req1_stb, i_req0_stb};

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_fifo
    uart_byte_fifo #(
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .push_i  (req_stb[gi]),
      .data_i  (req_data[gi]),
      .pop_i   (fifo_pop[gi]),
      .data_o  (fifo_head[gi]),
      .full_o  (fifo_full[gi]),
      .empty_o (fifo_empty[gi]),
      .count_o (fifo_count[gi])
    );
  end

  // Requester selection.  A held lock pins the grant to the owner; otherwise
  // the requester that did not send last wins when both have data.
  always_comb begin
    grant       = owner_q;
    grant_valid = 1'b0;
    if (locked_q) begin
      grant       = owner_q;
      grant_valid = !fifo_empty[owner_q];
    end else if (!fifo_empty[0] && !fifo_empty[1]) begin
      grant       = ~owner_q;
      grant_valid = 1'b1;
    end else if (!fifo_empty[0]) begin
      grant       = 1'b0;
      grant_valid = 1'b1;
    end else if (!fifo_empty[1]) begin
      grant       = 1'b1;
      grant_valid = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    owner_d   = owner_q;
    locked_d  = locked_q;
    idle_d    = '0;
    fifo_pop  = '0;

    // Lock watchdog: counts only while the owner has nothing to send and the
    // arbiter is free.  It is cleared on expiry, so it never exceeds the
    // timeout value and cannot wrap.
    if (locked_q && (state_q == ST_IDLE) && (fifo_count[owner_q] == '0)) begin
      if (idle_q >= IDLE_W'(LOCK_TIMEOUT - 1)) begin
        locked_d = 1'b0;
        idle_d   = '0;
      end else begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (grant_valid && !i_tx_busy) begin
          fifo_pop  = NUM_REQ'(1) << grant;
          tx_data_d = fifo_head[grant];
          owner_d   = grant;
          if (LINE_LOCK != 0) begin
            locked_d = (fifo_head[grant] != LINE_FEED);
          end
          state_d = ST_STROBE;
        end
      end
      ST_STROBE: state_d = ST_GAP;
      // The serializer may not have raised busy yet, so it is ignored here.
      ST_GAP:    state_d = ST_WAIT;
      ST_WAIT: begin
        if (!i_tx_busy) state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      tx_data_q <= 8'h00;
      owner_q   <= 1'b1;   // requester 0 wins the first round
      locked_q  <= 1'b0;
      idle_q    <= '0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      owner_q   <= owner_d;
      locked_q  <= locked_d;
      idle_q    <= idle_d;
    end
  end

  assign o_tx_stb    = (state_q == ST_STROBE);
  assign o_tx_data   = tx_data_q;
  assign o_owner     = owner_q;
  assign o_locked    = locked_q;
  assign o_req0_busy = fifo_full[0];
  assign o_req1_busy = fifo_full[1];

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter.  Two instances share every input: index 0 has
// line locking enabled (timeout 16), index 1 arbitrates per byte.  A
// queue-based reference model predicts every output each cycle.
module tb_uart_tx_arbiter;

  localparam int DEPTH = 4;
  localparam int TO    = 16;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       req0_stb = 1'b0, req1_stb = 1'b0, tx_busy = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;

  logic [7:0] tx_data [2];
  logic       tx_stb [2], owner [2], locked [2], busy0 [2], busy1 [2];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.FIFO_DEPTH(DEPTH), .LOCK_TIMEOUT(TO), .LINE_LOCK(1)) dut_lock (
    .i_clk(clk), .i_reset(i_reset),
    .i_req0_data(req0_data), .i_req0_stb(req0_stb), .o_req0_busy(busy0[0]),
    .i_req1_data(req1_data), .i_req1_stb(req1_stb), .o_req1_busy(busy1[0]),
    .o_tx_data(tx_data[0]), .o_tx_stb(tx_stb[0]), .i_tx_busy(tx_busy),
    .o_owner(owner[0]), .o_locked(locked[0])
  );

  uart_tx_arbiter #(.FIFO_DEPTH(DEPTH), .LOCK_TIMEOUT(TO), .LINE_LOCK(0)) dut_rr (
    .i_clk(clk), .i_reset(i_reset),
    .i_req0_data(req0_data), .i_req0_stb(req0_stb), .o_req0_busy(busy0[1]),
    .i_req1_data(req1_data), .i_req1_stb(req1_stb), .o_req1_busy(busy1[1]),
    .o_tx_data(tx_data[1]), .o_tx_stb(tx_stb[1]), .i_tx_busy(tx_busy),
    .o_owner(owner[1]), .o_locked(locked[1])
  );

  // Reference model state: per instance, per requester byte queue, plus the
  // send pipeline position (0 free, 1 strobe, 2 gap, 3 waiting on serializer).
  int         m_cnt [2][2];
  logic [7:0] m_buf [2][2][DEPTH];
  int         m_phase [2];
  logic [7:0] m_data [2];
  int         m_owner [2];
  int         m_locked [2];
  int         m_idle [2];

  int n_pass = 0, n_checks = 0, cyc = 0;
  int ser_len = 1, ser_left = 0;
  bit force_busy = 1'b0;

  function automatic logic [12:0] exp_vec(int m);
    return {m_phase[m] == 1, m_data[m], m_owner[m] != 0, m_locked[m] != 0,
            m_cnt[m][1] == DEPTH, m_cnt[m][0] == DEPTH};
  endfunction

  function automatic logic [12:0] got_vec(int m);
    return {tx_stb[m], tx_data[m], owner[m], locked[m], busy1[m], busy0[m]};
  endfunction

  task automatic model_update();
    bit full0, full1, pop;
    int sel;
    for (int m = 0; m < 2; m++) begin
      if (i_reset) begin
        m_cnt[m][0] = 0; m_cnt[m][1] = 0; m_phase[m] = 0; m_data[m] = 8'h00;
        m_owner[m] = 1; m_locked[m] = 0; m_idle[m] = 0;
      end else begin
        full0 = (m_cnt[m][0] == DEPTH);
        full1 = (m_cnt[m][1] == DEPTH);
        pop = 1'b0;
        sel = 0;
        if (m_phase[m] == 0 && !tx_busy) begin
          if (m_locked[m] != 0) begin
            sel = m_owner[m];
            pop = (m_cnt[m][sel] > 0);
          end else if (m_cnt[m][0] > 0 && m_cnt[m][1] > 0) begin
            sel = 1 - m_owner[m];
            pop = 1'b1;
          end else if (m_cnt[m][0] > 0) begin
            sel = 0; pop = 1'b1;
          end else if (m_cnt[m][1] > 0) begin
            sel = 1; pop = 1'b1;
          end
        end
        if (m_locked[m] != 0 && m_phase[m] == 0 && m_cnt[m][m_owner[m]] == 0) begin
          m_idle[m]++;
          if (m_idle[m] >= TO) begin
            m_locked[m] = 0;
            m_idle[m] = 0;
          end
        end else begin
          m_idle[m] = 0;
        end
        if (pop) begin
          m_data[m] = m_buf[m][sel][0];
          for (int k = 0; k < DEPTH - 1; k++) m_buf[m][sel][k] = m_buf[m][sel][k+1];
          m_cnt[m][sel]--;
          m_owner[m] = sel;
          if (m == 0) m_locked[m] = (m_data[m] != 8'h0A) ? 1 : 0;
          m_phase[m] = 1;
        end else if (m_phase[m] == 1) begin
          m_phase[m] = 2;
        end else if (m_phase[m] == 2) begin
          m_phase[m] = 3;
        end else if (m_phase[m] == 3 && !tx_busy) begin
          m_phase[m] = 0;
        end
        if (req0_stb && !full0) begin
          m_buf[m][0][m_cnt[m][0]] = req0_data;
          m_cnt[m][0]++;
        end
        if (req1_stb && !full1) begin
          m_buf[m][1][m_cnt[m][1]] = req1_data;
          m_cnt[m][1]++;
        end
      end
    end
  endtask

  // One clock: drive inputs at the falling edge, advance the model at the
  // rising edge, leave outputs settled 1 time unit later.  The serializer
  // stand-in stays busy for ser_len cycles after any strobe.
  task automatic step(input bit s0, input logic [7:0] d0, input bit s1,
                      input logic [7:0] d1, input bit rst);
    @(negedge clk);
    req0_stb = s0; req0_data = d0; req1_stb = s1; req1_data = d1; i_reset = rst;
    tx_busy = force_busy || (ser_left > 0);
    @(posedge clk);
    model_update();
    #1;
    cyc++;
    if (ser_left > 0) ser_left--;
    if (m_phase[0] == 1 || m_phase[1] == 1) ser_left = ser_len;
    for (int m = 0; m < 2; m++)
      if (tx_stb[m] === 1'b1)
        $display("tx cyc=%0d dut%0d data=%02h owner=%0d locked=%0d",
                 cyc, m, tx_data[m], owner[m], locked[m]);
  endtask

  task automatic test_reset();
    force_busy = 1'b0; ser_left = 0; ser_len = 1;
    repeat (2) begin
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      for (int m = 0; m < 2; m++) begin
        n_checks++;
        if (got_vec(m) !== exp_vec(m))
          $display("FAIL reset_model dut%0d cyc=%0d got=%h exp=%h", m, cyc, got_vec(m), exp_vec(m));
        else n_pass++;
      end
    end
    n_checks++;
    if ({tx_stb[0], tx_data[0], owner[0], locked[0], busy0[0], busy1[0]} !== {1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset_values got stb=%b data=%02h owner=%b locked=%b busy=%b%b exp 0/00/1/0/00",
               tx_stb[0], tx_data[0], owner[0], locked[0], busy1[0], busy0[0]);
    else n_pass++;
  endtask

  task automatic test_single_byte();
    ser_len = 4;
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h41, 1'b0, 8'h00, 1'b0);  // edge E
    n_checks++;
    if (tx_stb[0] !== 1'b0) $display("FAIL single_early got stb=%b exp 0", tx_stb[0]);
    else n_pass++;
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);  // edge E+1: strobe follows
    n_checks++;
    if ({tx_stb[0], tx_data[0], owner[0], locked[0], locked[1]} !== {1'b1, 8'h41, 1'b0, 1'b1, 1'b0})
      $display("FAIL single_strobe got stb=%b data=%02h owner=%b locked=%b/%b exp 1/41/0/1/0",
               tx_stb[0], tx_data[0], owner[0], locked[0], locked[1]);
    else n_pass++;
    repeat (12) begin
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      n_checks++;
      if (tx_stb[0] !== 1'b0) $display("FAIL single_extra_stb cyc=%0d got stb=1 exp 0", cyc);
      else n_pass++;
      for (int m = 0; m < 2; m++) begin
        n_checks++;
        if (got_vec(m) !== exp_vec(m))
          $display("FAIL single_model dut%0d cyc=%0d got=%h exp=%h", m, cyc, got_vec(m), exp_vec(m));
        else n_pass++;
      end
    end
  endtask

  task automatic test_line_lock();
    logic [7:0] a [3];
    logic [7:0] b [2];
    logic [7:0] exp_b [5];
    logic       exp_o [5];
    logic       exp_l [5];
    logic [7:0] seen_b [5];
    logic       seen_o [5];
    logic       seen_l [5];
    int n = 0;
    a = '{8'h41, 8'h42, 8'h0A};
    b = '{8'h78, 8'h79};
    exp_b = '{8'h41, 8'h42, 8'h0A, 8'h78, 8'h79};
    exp_o = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_l = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    ser_len = 10;
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    for (int c = 0; c < 200 && n < 5; c++) begin
      if (c < 3) step(1'b1, a[c], c < 2, b[c % 2], 1'b0);
      else       step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      if (tx_stb[0] === 1'b1) begin
        seen_b[n] = tx_data[0]; seen_o[n] = owner[0]; seen_l[n] = locked[0]; n++;
      end
      for (int m = 0; m < 2; m++) begin
        n_checks++;
        if (got_vec(m) !== exp_vec(m))
          $display("FAIL lock_model dut%0d cyc=%0d got=%h exp=%h", m, cyc, got_vec(m), exp_vec(m));
        else n_pass++;
      end
    end
    n_checks++;
    if (n != 5) $display("FAIL lock_count got %0d strobes exp 5", n);
    else n_pass++;
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if ({seen_b[i], seen_o[i], seen_l[i]} !== {exp_b[i], exp_o[i], exp_l[i]})
        $display("FAIL lock_order #%0d got %02h/owner%b/locked%b exp %02h/owner%b/locked%b",
                 i, seen_b[i], seen_o[i], seen_l[i], exp_b[i], exp_o[i], exp_l[i]);
      else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] a [3];
    logic [7:0] b [3];
    int n = 0;
    for (int i = 0; i < 3; i++) begin
      a[i] = 8'($urandom); b[i] = 8'($urandom);
    end
    ser_len = $urandom_range(1, 6);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    for (int c = 0; c < 200 && n < 6; c++) begin
      if (c < 3) step(1'b1, a[c], 1'b1, b[c], 1'b0);
      else       step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      if (tx_stb[1] === 1'b1) begin
        n_checks++;
        if ({owner[1], tx_data[1]} !== {n[0], (n[0] ? b[n/2] : a[n/2])})
          $display("FAIL rr_order #%0d got owner%b/%02h exp owner%b/%02h",
                   n, owner[1], tx_data[1], n[0], (n[0] ? b[n/2] : a[n/2]));
        else n_pass++;
        n++;
      end
      for (int m = 0; m < 2; m++) begin
        n_checks++;
        if (got_vec(m) !== exp_vec(m))
          $display("FAIL rr_model dut%0d cyc=%0d got=%h exp=%h", m, cyc, got_vec(m), exp_vec(m));
        else n_pass++;
      end
    end
    n_checks++;
    if (n != 6) $display("FAIL rr_count got %0d strobes exp 6", n);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [7:0] b [5];
    int n = 0;
    for (int i = 0; i < 5; i++) b[i] = 8'($urandom);
    ser_len = 2;
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    force_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h00, 1'b1, b[i], 1'b0);
      n_checks++;
      if (busy1[0] !== (i >= 3)) $display("FAIL bp_busy after push %0d got %b exp %b", i + 1, busy1[0], i >= 3);
      else n_pass++;
    end
    force_busy = 1'b0;
    for (int c = 0; c < 100; c++) begin
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      if (tx_stb[0] === 1'b1) begin
        n_checks++;
        if (n >= 4 || tx_data[0] !== b[n])
          $display("FAIL bp_data #%0d got %02h exp %02h", n, tx_data[0], (n < 4) ? b[n] : 8'h00);
        else n_pass++;
        n++;
      end
      for (int m = 0; m < 2; m++) begin
        n_checks++;
        if (got_vec(m) !== exp_vec(m))
          $display("FAIL bp_model dut%0d cyc=%0d got=%h exp=%h", m, cyc, got_vec(m), exp_vec(m));
        else n_pass++;
      end
    end
    n_checks++;
    if (n != 4) $display("FAIL bp_count got %0d strobes exp 4", n);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int t_a = -1, t_u = -1, t_b = -1;
    ser_len = 3;
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    for (int c = 0; c < 100 && t_b < 0; c++) begin
      if (c == 0)      step(1'b1, 8'h41, 1'b0, 8'h00, 1'b0);
      else if (c == 4) step(1'b0, 8'h00, 1'b1, 8'h5A, 1'b0);
      else             step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      if (tx_stb[0] === 1'b1 && tx_data[0] === 8'h41 && locked[0] === 1'b1) t_a = cyc;
      if (t_a >= 0 && t_u < 0 && locked[0] === 1'b0) t_u = cyc;
      if (t_u >= 0 && tx_stb[0] === 1'b1 && owner[0] === 1'b1 && tx_data[0] === 8'h5A && locked[0] === 1'b1) t_b = cyc;
      for (int m = 0; m < 2; m++) begin
        n_checks++;
        if (got_vec(m) !== exp_vec(m))
          $display("FAIL to_model dut%0d cyc=%0d got=%h exp=%h", m, cyc, got_vec(m), exp_vec(m));
        else n_pass++;
      end
    end
    // Strobe, gap, 2 busy wait cycles, back in idle, then 16 idle cycles.
    n_checks++;
    if (t_a < 0 || t_u - t_a != 20)
      $display("FAIL to_unlock got lock-to-unlock %0d cycles (strobe seen %0d) exp 20", t_u - t_a, t_a);
    else n_pass++;
    n_checks++;
    if (t_u < 0 || t_b - t_u != 1)
      $display("FAIL to_relock got unlock-to-req1-strobe %0d cycles exp 1", t_b - t_u);
    else n_pass++;
  endtask

  task automatic test_reset_mid_send();
    int n = 0;
    bit found = 1'b0;
    ser_len = 10;
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    for (int c = 0; c < 50 && !found; c++) begin
      if (c < 3) step(1'b1, 8'($urandom), 1'b0, 8'h00, 1'b0);
      else       step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      found = (m_phase[0] == 3 && m_cnt[0][0] == 2);
    end
    n_checks++;
    if (!found) $display("FAIL rst_mid_setup got no wait phase with 2 queued exp found");
    else n_pass++;
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if ({tx_stb[m], busy0[m], busy1[m]} !== 3'b000)
        $display("FAIL rst_mid_abort dut%0d got stb/busy0/busy1=%b%b%b exp 000", m, tx_stb[m], busy0[m], busy1[m]);
      else n_pass++;
    end
    force_busy = 1'b0; ser_left = 0;
    repeat (30) begin
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      if (tx_stb[0] === 1'b1 || tx_stb[1] === 1'b1) n++;
      for (int m = 0; m < 2; m++) begin
        n_checks++;
        if (got_vec(m) !== exp_vec(m))
          $display("FAIL rst_mid_model dut%0d cyc=%0d got=%h exp=%h", m, cyc, got_vec(m), exp_vec(m));
        else n_pass++;
      end
    end
    n_checks++;
    if (n != 0) $display("FAIL rst_mid_quiet got %0d strobes exp 0", n);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] d0, d1;
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    for (int c = 0; c < 600; c++) begin
      if (c % 40 == 0) ser_len = $urandom_range(0, 8);
      force_busy = ($urandom_range(0, 9) == 0);
      d0 = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
      d1 = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
      step($urandom_range(0, 2) == 0, d0, $urandom_range(0, 2) == 0, d1,
           $urandom_range(0, 199) == 0);
      for (int m = 0; m < 2; m++) begin
        n_checks++;
        if (got_vec(m) !== exp_vec(m))
          $display("FAIL rand_model dut%0d cyc=%0d got=%h exp=%h", m, cyc, got_vec(m), exp_vec(m));
        else n_pass++;
      end
    end
    force_busy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_line_lock();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_reset_mid_send();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got no completion exp finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
